alu1_ctrl_solver: RTL and testbench

- Inverse of the 12-in/8-out alu1 control function. Given operands A, B and a target 8-bit result, it searches the 16 control codes one per cycle.
- Reports the lowest code that reproduces the target, plus a mask of matching codes.
- Sits beside alu1 as its control-code recovery (decode) engine.
- Uses valid/ready handshakes on both sides.

---
 rtl/alu1_ctrl_solver.sv | 171 +++++++++++++++++
 tb/tb_alu1_ctrl_solver.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu1_ctrl_solver.sv
// rtl/alu1_ctrl_solver.sv - control-code recovery engine for the alu1 control function
//
// Given operands A, B and a target result, walks the 16 alu1 control codes
// one per cycle and reports the lowest code that reproduces the target,
// together with a mask of every matching code examined.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous active-low reset
//   in_valid   - request valid
//   in_ready   - request accepted when in_valid & in_ready
//   in_a       - operand A (4 bits)
//   in_b       - operand B (4 bits)
//   in_target  - desired 8-bit alu1 result
//   out_valid  - result valid
//   out_ready  - result consumed when out_valid & out_ready
//   out_found  - at least one code matched
//   out_code   - lowest matching code {c11,c10,c9,c8}; 0 if none
//   out_mask   - bit k set if code k matched
//
// Parameter:
//   EARLY_EXIT - 1: stop at the first matching code; 0: always scan all 16

module alu1_ctrl_solver #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_a,
    input  logic [3:0]  in_b,
    input  logic [7:0]  in_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_found,
    output logic [3:0]  out_code,
    output logic [15:0] out_mask
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  a_q, a_d;
    logic [3:0]  b_q, b_d;
    logic [7:0]  target_q, target_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] mask_q, mask_d;
    logic        found_q, found_d;
    logic [3:0]  code_q, code_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;

    logic [7:0]  result;
    logic        hit;

    // alu1 control function; code bit 0 is c8, bit 3 is c11.
    function automatic logic [7:0] alu1_eval(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic [3:0] k
    );
        logic [7:0] r;
        r = 8'd0;
        for (int i = 0; i < 4; i++) begin
            r[i] = ~a[i] | ~(b[i] ? k[3] : k[2]);
        end
        for (int i = 0; i < 3; i++) begin
            r[4+i] = ~a[i] & ~(b[i] ? k[0] : k[1]);
        end
        // Top bit does not follow the generic select pattern.
        r[7] = ~a[3] & b[3] & ~k[0];
        return r;
    endfunction

    assign result = alu1_eval(a_q, b_q, idx_q);
    assign hit    = (result == target_q);

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        target_d    = target_q;
        idx_d       = idx_q;
        mask_d      = mask_q;
        found_d     = found_q;
        code_d      = code_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d        = in_a;
                    b_d        = in_b;
                    target_d   = in_target;
                    idx_d      = 4'd0;
                    mask_d     = 16'd0;
                    found_d    = 1'b0;
                    code_d     = 4'd0;
                    in_ready_d = 1'b0;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                mask_d[idx_q] = hit;
                // Scan runs upward, so the first hit is the lowest code.
                if (hit && !found_q) begin
                    found_d = 1'b1;
                    code_d  = idx_q;
                end
                // Exit at idx 15 takes priority, so idx never wraps.
                if ((hit && EARLY_EXIT) || (idx_q == 4'd15)) begin
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= 4'd0;
            b_q         <= 4'd0;
            target_q    <= 8'd0;
            idx_q       <= 4'd0;
            mask_q      <= 16'd0;
            found_q     <= 1'b0;
            code_q      <= 4'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            target_q    <= target_d;
            idx_q       <= idx_d;
            mask_q      <= mask_d;
            found_q     <= found_d;
            code_q      <= code_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_found = found_q;
    assign out_code  = code_q;
    assign out_mask  = mask_q;

endmodule

// File: tb/tb_alu1_ctrl_solver.sv
// tb/tb_alu1_ctrl_solver.sv - directed and random checks of alu1_ctrl_solver in both EARLY_EXIT modes

module tb_alu1_ctrl_solver;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_a;
    logic [3:0]  in_b;
    logic [7:0]  in_target;

    logic        in_valid_e1, in_ready_e1, out_valid_e1, out_ready_e1, out_found_e1;
    logic [3:0]  out_code_e1;
    logic [15:0] out_mask_e1;

    logic        in_valid_e0, in_ready_e0, out_valid_e0, out_ready_e0, out_found_e0;
    logic [3:0]  out_code_e0;
    logic [15:0] out_mask_e0;

    int tests_run = 0;
    int failed    = 0;

    alu1_ctrl_solver #(.EARLY_EXIT(1'b1)) u_e1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_e1), .in_ready(in_ready_e1),
        .in_a(in_a), .in_b(in_b), .in_target(in_target),
        .out_valid(out_valid_e1), .out_ready(out_ready_e1),
        .out_found(out_found_e1), .out_code(out_code_e1), .out_mask(out_mask_e1)
    );

    alu1_ctrl_solver #(.EARLY_EXIT(1'b0)) u_e0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_e0), .in_ready(in_ready_e0),
        .in_a(in_a), .in_b(in_b), .in_target(in_target),
        .out_valid(out_valid_e0), .out_ready(out_ready_e0),
        .out_found(out_found_e0), .out_code(out_code_e0), .out_mask(out_mask_e0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference alu1 result written bit by bit from named control signals.
    function automatic logic [7:0] golden(input logic [3:0] a, input logic [3:0] b, input logic [3:0] k);
        logic c8, c9, c10, c11;
        logic [7:0] r;
        c8 = k[0]; c9 = k[1]; c10 = k[2]; c11 = k[3];
        r[0] = !(a[0] && (b[0] ? c11 : c10));
        r[1] = !(a[1] && (b[1] ? c11 : c10));
        r[2] = !(a[2] && (b[2] ? c11 : c10));
        r[3] = !(a[3] && (b[3] ? c11 : c10));
        r[4] = !a[0] && !(b[0] ? c8 : c9);
        r[5] = !a[1] && !(b[1] ? c8 : c9);
        r[6] = !a[2] && !(b[2] ? c8 : c9);
        r[7] = !a[3] && b[3] && !c8;
        return r;
    endfunction

    // Issues one request, scrambles the inputs after accept, waits (bounded)
    // for out_valid, captures the result, then completes the handshake.
    task automatic run_req(input bit ee, input logic [3:0] a, input logic [3:0] b,
                           input logic [7:0] t, output int lat, output logic f,
                           output logic [3:0] c, output logic [15:0] m);
        logic ov;
        @(negedge clk);
        in_a = a; in_b = b; in_target = t;
        if (ee) in_valid_e1 = 1'b1; else in_valid_e0 = 1'b1;
        @(posedge clk); #1;
        in_valid_e1 = 1'b0; in_valid_e0 = 1'b0;
        in_a = ~a; in_b = ~b; in_target = ~t;
        lat = 0;
        ov  = 1'b0;
        while (!ov && lat <= 40) begin
            @(posedge clk); #1;
            lat++;
            ov = ee ? out_valid_e1 : out_valid_e0;
        end
        f = ee ? out_found_e1 : out_found_e0;
        c = ee ? out_code_e1  : out_code_e0;
        m = ee ? out_mask_e1  : out_mask_e0;
        if (ee) out_ready_e1 = 1'b1; else out_ready_e0 = 1'b1;
        @(posedge clk); #1;
        out_ready_e1 = 1'b0; out_ready_e0 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({in_ready_e1, out_valid_e1, out_found_e1, out_code_e1, out_mask_e1} !== {1'b1, 1'b0, 1'b0, 4'd0, 16'd0}) begin
            failed++;
            $display("FAIL reset_e1: rdy=%b vld=%b found=%b code=%h mask=%h, required rdy=1 vld=0 found=0 code=0 mask=0000",
                     in_ready_e1, out_valid_e1, out_found_e1, out_code_e1, out_mask_e1);
        end
        tests_run++;
        if ({in_ready_e0, out_valid_e0, out_found_e0, out_code_e0, out_mask_e0} !== {1'b1, 1'b0, 1'b0, 4'd0, 16'd0}) begin
            failed++;
            $display("FAIL reset_e0: rdy=%b vld=%b found=%b code=%h mask=%h, required rdy=1 vld=0 found=0 code=0 mask=0000",
                     in_ready_e0, out_valid_e0, out_found_e0, out_code_e0, out_mask_e0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_early_exit();
        int lat; logic f; logic [3:0] c; logic [15:0] m;
        run_req(1'b1, 4'h0, 4'hF, 8'hFF, lat, f, c, m);
        tests_run++;
        if ({lat, f, c, m} !== {32'd1, 1'b1, 4'd0, 16'h0001}) begin
            failed++;
            $display("FAIL early_exit_code0: lat=%0d found=%b code=%h mask=%h, required lat=1 found=1 code=0 mask=0001", lat, f, c, m);
        end
        run_req(1'b1, 4'hF, 4'h0, 8'h00, lat, f, c, m);
        tests_run++;
        if ({lat, f, c, m} !== {32'd5, 1'b1, 4'd4, 16'h0010}) begin
            failed++;
            $display("FAIL early_exit_code4: lat=%0d found=%b code=%h mask=%h, required lat=5 found=1 code=4 mask=0010", lat, f, c, m);
        end
    endtask

    task automatic test_full_scan();
        int lat; logic f; logic [3:0] c; logic [15:0] m;
        run_req(1'b0, 4'h0, 4'hF, 8'h0F, lat, f, c, m);
        tests_run++;
        if ({lat, f, c, m} !== {32'd16, 1'b1, 4'd1, 16'hAAAA}) begin
            failed++;
            $display("FAIL full_scan_0f: lat=%0d found=%b code=%h mask=%h, required lat=16 found=1 code=1 mask=aaaa", lat, f, c, m);
        end
        run_req(1'b0, 4'h0, 4'hF, 8'hFF, lat, f, c, m);
        tests_run++;
        if ({lat, f, c, m} !== {32'd16, 1'b1, 4'd0, 16'h5555}) begin
            failed++;
            $display("FAIL full_scan_ff: lat=%0d found=%b code=%h mask=%h, required lat=16 found=1 code=0 mask=5555", lat, f, c, m);
        end
        run_req(1'b0, 4'hF, 4'h0, 8'h00, lat, f, c, m);
        tests_run++;
        if ({lat, f, c, m} !== {32'd16, 1'b1, 4'd4, 16'hF0F0}) begin
            failed++;
            $display("FAIL full_scan_f0: lat=%0d found=%b code=%h mask=%h, required lat=16 found=1 code=4 mask=f0f0", lat, f, c, m);
        end
    endtask

    task automatic test_no_match();
        int lat; logic f; logic [3:0] c; logic [15:0] m;
        run_req(1'b1, 4'h0, 4'h5, 8'h00, lat, f, c, m);
        tests_run++;
        if ({lat, f, c, m} !== {32'd16, 1'b0, 4'd0, 16'h0000}) begin
            failed++;
            $display("FAIL no_match_e1: lat=%0d found=%b code=%h mask=%h, required lat=16 found=0 code=0 mask=0000", lat, f, c, m);
        end
        run_req(1'b0, 4'h0, 4'hA, 8'h00, lat, f, c, m);
        tests_run++;
        if ({lat, f, c, m} !== {32'd16, 1'b0, 4'd0, 16'h0000}) begin
            failed++;
            $display("FAIL no_match_e0: lat=%0d found=%b code=%h mask=%h, required lat=16 found=0 code=0 mask=0000", lat, f, c, m);
        end
    endtask

    task automatic test_reset_mid_scan();
        int lat; logic f; logic [3:0] c; logic [15:0] m;
        @(negedge clk);
        in_a = 4'h0; in_b = 4'hF; in_target = 8'hFF; in_valid_e0 = 1'b1;
        @(posedge clk); #1;
        in_valid_e0 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tests_run++;
        if ({in_ready_e0, out_valid_e0, out_found_e0, out_code_e0, out_mask_e0} !== {1'b1, 1'b0, 1'b0, 4'd0, 16'd0}) begin
            failed++;
            $display("FAIL reset_mid_scan: rdy=%b vld=%b found=%b code=%h mask=%h, required rdy=1 vld=0 found=0 code=0 mask=0000",
                     in_ready_e0, out_valid_e0, out_found_e0, out_code_e0, out_mask_e0);
        end
        repeat (20) @(posedge clk);
        #1;
        tests_run++;
        if (out_valid_e0 !== 1'b0) begin
            failed++;
            $display("FAIL reset_mid_scan_abort: out_valid=%b, required 0", out_valid_e0);
        end
        run_req(1'b0, 4'h0, 4'hF, 8'hFF, lat, f, c, m);
        tests_run++;
        if ({lat, f, c, m} !== {32'd16, 1'b1, 4'd0, 16'h5555}) begin
            failed++;
            $display("FAIL reset_mid_scan_retry: lat=%0d found=%b code=%h mask=%h, required lat=16 found=1 code=0 mask=5555", lat, f, c, m);
        end
    endtask

    task automatic test_back_pressure();
        int lat;
        @(negedge clk);
        in_a = 4'h0; in_b = 4'hF; in_target = 8'hFF; in_valid_e1 = 1'b1;
        @(posedge clk); #1;
        // Second request held pending while the first result is stalled.
        in_a = 4'hF; in_b = 4'h0; in_target = 8'h00;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({out_valid_e1, in_ready_e1, out_found_e1, out_code_e1, out_mask_e1} !== {1'b1, 1'b0, 1'b1, 4'd0, 16'h0001}) begin
                failed++;
                $display("FAIL back_pressure_hold[%0d]: vld=%b rdy=%b found=%b code=%h mask=%h, required vld=1 rdy=0 found=1 code=0 mask=0001",
                         i, out_valid_e1, in_ready_e1, out_found_e1, out_code_e1, out_mask_e1);
            end
        end
        out_ready_e1 = 1'b1;
        @(posedge clk); #1;
        out_ready_e1 = 1'b0;
        tests_run++;
        if ({in_ready_e1, out_valid_e1} !== 2'b10) begin
            failed++;
            $display("FAIL back_pressure_release: rdy=%b vld=%b, required rdy=1 vld=0", in_ready_e1, out_valid_e1);
        end
        @(posedge clk); #1;
        in_valid_e1 = 1'b0;
        lat = 0;
        while (out_valid_e1 !== 1'b1 && lat <= 40) begin
            @(posedge clk); #1;
            lat++;
        end
        tests_run++;
        if ({lat, out_found_e1, out_code_e1, out_mask_e1} !== {32'd5, 1'b1, 4'd4, 16'h0010}) begin
            failed++;
            $display("FAIL back_pressure_second: lat=%0d found=%b code=%h mask=%h, required lat=5 found=1 code=4 mask=0010",
                     lat, out_found_e1, out_code_e1, out_mask_e1);
        end
        out_ready_e1 = 1'b1;
        @(posedge clk); #1;
        out_ready_e1 = 1'b0;
    endtask

    task automatic test_random();
        int lat, exp_lat;
        logic f, exp_f;
        logic [3:0] c, exp_c, a, b;
        logic [15:0] m, exp_m;
        logic [7:0] t;
        bit stop;
        for (int ee = 1; ee >= 0; ee--) begin
            for (int n = 0; n < 1000; n++) begin
                a = 4'($urandom);
                b = 4'($urandom);
                // Half the targets come from a real code so matches are common.
                if ($urandom_range(1, 0) == 1) t = golden(a, b, 4'($urandom));
                else t = 8'($urandom);
                exp_f = 1'b0; exp_c = 4'd0; exp_m = 16'd0; exp_lat = 16; stop = 1'b0;
                for (int k = 0; k < 16; k++) begin
                    if (!stop && golden(a, b, 4'(k)) == t) begin
                        exp_m[k] = 1'b1;
                        if (!exp_f) begin
                            exp_f = 1'b1;
                            exp_c = 4'(k);
                            if (ee == 1) begin
                                exp_lat = k + 1;
                                stop = 1'b1;
                            end
                        end
                    end
                end
                run_req(ee[0], a, b, t, lat, f, c, m);
                tests_run++;
                if ({lat, f, c, m} !== {exp_lat, exp_f, exp_c, exp_m}) begin
                    failed++;
                    $display("FAIL random_ee%0d[%0d] a=%h b=%h t=%h: lat=%0d found=%b code=%h mask=%h, required lat=%0d found=%b code=%h mask=%h",
                             ee, n, a, b, t, lat, f, c, m, exp_lat, exp_f, exp_c, exp_m);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_a = 4'h0; in_b = 4'h0; in_target = 8'h00;
        in_valid_e1 = 1'b0; out_ready_e1 = 1'b0;
        in_valid_e0 = 1'b0; out_ready_e0 = 1'b0;
        test_reset();
        test_early_exit();
        test_full_scan();
        test_no_match();
        test_reset_mid_scan();
        test_back_pressure();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
